// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin arbiter and sequencer in front of one shared ALU.
// Build option ALU_ARB_OPCHECK_EN: when defined, ops not set in LEGAL_OPS return resp_err=1 with a zero result and zero flags.
//
// ALU ports:
//   a, b      in  n  operands
//   alu_ctrl  in  4  operation code (0 add, 1 sub, 2 and, 3 or, 4 xor, 5 not a)
//   result    out n  result
//   z,nf,v,c  out 1  zero, negative, signed overflow, carry/borrow
//
// alu_arbiter ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   req_valid/req_ready [1:0]   per-requester request handshake
//   req_a0/req_b0/req_op0       requester 0 operands and ALU control
//   req_a1/req_b1/req_op1       requester 1 operands and ALU control
//   resp_valid/resp_ready [1:0] per-requester response handshake
//   resp_result, resp_flags     registered result and {Z,N,V,C}
//   resp_err                    illegal-op indication

module ALU #(
    parameter int n = 3
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic [3:0]   alu_ctrl,
    output logic [n-1:0] result,
    output logic         z,
    output logic         nf,
    output logic         v,
    output logic         c
);

    logic [n:0] sum;
    logic [n:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = '0;
        v      = 1'b0;
        c      = 1'b0;
        case (alu_ctrl)
            4'd0: begin
                result = sum[n-1:0];
                c      = sum[n];
                v      = (a[n-1] ~^ b[n-1]) & (sum[n-1] ^ a[n-1]);
            end
            4'd1: begin
                // c is the borrow out of a - b
                result = diff[n-1:0];
                c      = diff[n];
                v      = (a[n-1] ^ b[n-1]) & (diff[n-1] ^ a[n-1]);
            end
            4'd2: result = a & b;
            4'd3: result = a | b;
            4'd4: result = a ^ b;
            4'd5: result = ~a;
            default: result = '0;
        endcase
    end

    assign z  = (result == '0);
    assign nf = result[n-1];

endmodule

module alu_arbiter #(
    parameter int          n         = 3,
    parameter logic [15:0] LEGAL_OPS = 16'h003F
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [n-1:0] req_a0,
    input  logic [n-1:0] req_b0,
    input  logic [3:0]   req_op0,
    input  logic [n-1:0] req_a1,
    input  logic [n-1:0] req_b1,
    input  logic [3:0]   req_op1,
    output logic [1:0]   resp_valid,
    input  logic [1:0]   resp_ready,
    output logic [n-1:0] resp_result,
    output logic [3:0]   resp_flags,
    output logic         resp_err
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t state_q;
    state_t state_d;

    logic         sel;
    logic         take;
    logic         last;
    logic         gnt;
    logic [n-1:0] op_a;
    logic [n-1:0] op_b;
    logic [3:0]   op_c;
    logic [n-1:0] sel_a;
    logic [n-1:0] sel_b;
    logic [3:0]   sel_op;

    logic [n-1:0] alu_result;
    logic         alu_z;
    logic         alu_n;
    logic         alu_v;
    logic         alu_c;
    logic         exec_bad;

    // Round-robin: a lone request wins; on a tie the one not served last wins.
    always_comb begin
        sel = 1'b0;
        case (req_valid)
            2'b01:   sel = 1'b0;
            2'b10:   sel = 1'b1;
            2'b11:   sel = ~last;
            default: sel = 1'b0;
        endcase
    end

    assign sel_a  = sel ? req_a1  : req_a0;
    assign sel_b  = sel ? req_b1  : req_b0;
    assign sel_op = sel ? req_op1 : req_op0;

    always_comb begin
        state_d   = state_q;
        req_ready = 2'b00;
        take      = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready[sel] = 1'b1;
                    take           = 1'b1;
                    state_d        = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                if (resp_ready[gnt]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The ALU only ever sees the latched operands, so requesters may
    // change their inputs as soon as the request handshake completes.
    ALU #(.n(n)) u_alu (
        .a        (op_a),
        .b        (op_b),
        .alu_ctrl (op_c),
        .result   (alu_result),
        .z        (alu_z),
        .nf       (alu_n),
        .v        (alu_v),
        .c        (alu_c)
    );

`ifdef ALU_ARB_OPCHECK_EN
    logic op_bad_q;
    logic err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_bad_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (take) begin
                op_bad_q <= ~LEGAL_OPS[sel_op];
            end
            if (state_q == EXEC) begin
                err_q <= op_bad_q;
            end
        end
    end

    assign exec_bad = op_bad_q;
    assign resp_err = err_q;
`else
    logic unused_legal;

    assign unused_legal = ^LEGAL_OPS;
    assign exec_bad     = 1'b0;
    assign resp_err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last        <= 1'b1;
            gnt         <= 1'b0;
            op_a        <= '0;
            op_b        <= '0;
            op_c        <= '0;
            resp_valid  <= 2'b00;
            resp_result <= '0;
            resp_flags  <= '0;
        end else begin
            if (take) begin
                op_a <= sel_a;
                op_b <= sel_b;
                op_c <= sel_op;
                gnt  <= sel;
                last <= sel;
            end
            if (state_q == EXEC) begin
                // An illegal op still spends its EXEC cycle but reports zeros.
                resp_result <= exec_bad ? '0 : alu_result;
                resp_flags  <= exec_bad ? 4'b0000
                                        : {alu_z, alu_n, alu_v, alu_c};
                resp_valid  <= gnt ? 2'b10 : 2'b01;
            end
            if (state_q == RESP && resp_ready[gnt]) begin
                resp_valid <= 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed-vector bench for alu_arbiter.
// Expected values are hand-computed for the 3-bit ALU op table.

module tb_alu_arbiter;

    logic       clk;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [2:0] req_a0;
    logic [2:0] req_b0;
    logic [3:0] req_op0;
    logic [2:0] req_a1;
    logic [2:0] req_b1;
    logic [3:0] req_op1;
    logic [1:0] resp_valid;
    logic [1:0] resp_ready;
    logic [2:0] resp_result;
    logic [3:0] resp_flags;
    logic       resp_err;

    int vecs;
    int errs;

    logic [1:0] g;
    logic [2:0] er;
    logic [3:0] ef;

    alu_arbiter #(.n(3), .LEGAL_OPS(16'h003F)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a0      (req_a0),
        .req_b0      (req_b0),
        .req_op0     (req_op0),
        .req_a1      (req_a1),
        .req_b1      (req_b1),
        .req_op1     (req_op1),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_flags  (resp_flags),
        .resp_err    (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_rv"},  32'(resp_valid),  32'h0);
        check({tag, "_res"}, 32'(resp_result), 32'h0);
        check({tag, "_flg"}, 32'(resp_flags),  32'h0);
        check({tag, "_err"}, 32'(resp_err),    32'h0);
        check({tag, "_rdy"}, 32'(req_ready),   32'h0);
    endtask

    initial begin
        vecs       = 0;
        errs       = 0;
        rst_n      = 1'b0;
        req_valid  = 2'b00;
        resp_ready = 2'b00;
        req_a0     = '0;
        req_b0     = '0;
        req_op0    = '0;
        req_a1     = '0;
        req_b1     = '0;
        req_op1    = '0;
        tick();
        tick();
        #1;
        check_idle_zero("reset");
        rst_n = 1'b1;

        // Single request: 5 + 3 = 8 -> 000, Z=1 C=1
        req_a0     = 3'b101;
        req_b0     = 3'b011;
        req_op0    = 4'd0;
        resp_ready = 2'b11;
        req_valid  = 2'b01;
        #1;
        check("t1_rdy_c0", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b00;
        #1;
        check("t1_rv_c1", 32'(resp_valid), 32'h0);
        check("t1_rdy_c1", 32'(req_ready), 32'h0);
        tick();
        #1;
        check("t1_rv_c2", 32'(resp_valid), 32'h1);
        check("t1_res", 32'(resp_result), 32'h0);
        check("t1_flg", 32'(resp_flags), 32'h9);
        check("t1_err", 32'(resp_err), 32'h0);
        tick();
        req_valid = 2'b01;
        #1;
        check("t1_rv_c3", 32'(resp_valid), 32'h0);
        check("t1_rdy_c3", 32'(req_ready), 32'h1);
        req_valid = 2'b00;

        // Round robin from reset: 0,1,0,1
        rst_n = 1'b0;
        tick();
        rst_n      = 1'b1;
        req_a0     = 3'b001;
        req_b0     = 3'b001;
        req_op0    = 4'd0;
        req_a1     = 3'b110;
        req_b1     = 3'b010;
        req_op1    = 4'd1;
        resp_ready = 2'b11;
        req_valid  = 2'b11;
        for (int i = 0; i < 4; i++) begin
            g  = (i % 2 == 1) ? 2'b10 : 2'b01;
            er = (i % 2 == 1) ? 3'b100 : 3'b010;
            ef = (i % 2 == 1) ? 4'b0100 : 4'b0000;
            #1;
            check("rr_gnt", 32'(req_ready), 32'(g));
            tick();
            tick();
            #1;
            check("rr_rv", 32'(resp_valid), 32'(g));
            check("rr_res", 32'(resp_result), 32'(er));
            check("rr_flg", 32'(resp_flags), 32'(ef));
            tick();
        end
        req_valid = 2'b00;

        // Backpressure on requester 1: 3 & 1 = 001
        req_a1     = 3'b011;
        req_b1     = 3'b001;
        req_op1    = 4'd2;
        resp_ready = 2'b01;
        req_valid  = 2'b10;
        #1;
        check("bp_gnt", 32'(req_ready), 32'h2);
        tick();
        tick();
        req_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_rv", 32'(resp_valid), 32'h2);
            check("bp_res", 32'(resp_result), 32'h1);
            check("bp_flg", 32'(resp_flags), 32'h0);
            check("bp_rdy", 32'(req_ready), 32'h0);
            tick();
        end
        resp_ready = 2'b10;
        req_valid  = 2'b00;
        tick();
        #1;
        check("bp_done_rv", 32'(resp_valid), 32'h0);

        // Operands changed after acceptance: 7 + 1 = 000, Z=1 C=1
        req_a0     = 3'b111;
        req_b0     = 3'b001;
        req_op0    = 4'd0;
        resp_ready = 2'b01;
        req_valid  = 2'b01;
        tick();
        req_a0    = 3'b000;
        req_valid = 2'b00;
        tick();
        #1;
        check("chg_rv", 32'(resp_valid), 32'h1);
        check("chg_res", 32'(resp_result), 32'h0);
        check("chg_flg", 32'(resp_flags), 32'h9);
        tick();

        // Reset during EXEC
        req_a0     = 3'b010;
        req_b0     = 3'b001;
        req_op0    = 4'd0;
        resp_ready = 2'b00;
        req_valid  = 2'b01;
        tick();
        req_valid = 2'b00;
        rst_n     = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check_idle_zero("rst_exec");
        req_valid = 2'b11;
        #1;
        check("rst_exec_tie", 32'(req_ready), 32'h1);
        req_valid = 2'b00;
        tick();
        #1;
        check("rst_exec_norsp", 32'(resp_valid), 32'h0);

        // Reset during RESP: 2 + 1 = 011
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        #1;
        check("rst_resp_rv", 32'(resp_valid), 32'h1);
        check("rst_resp_res", 32'(resp_result), 32'h3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check_idle_zero("rst_resp");
        req_valid = 2'b11;
        #1;
        check("rst_resp_tie", 32'(req_ready), 32'h1);
        req_valid = 2'b00;
        tick();
        #1;
        check("rst_resp_norsp", 32'(resp_valid), 32'h0);

        // Op 9 then op 1 (5 - 3 = 010, V=1)
        req_a0     = 3'b101;
        req_b0     = 3'b011;
        req_op0    = 4'd9;
        resp_ready = 2'b01;
        req_valid  = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        #1;
        check("op9_rv", 32'(resp_valid), 32'h1);
`ifdef ALU_ARB_OPCHECK_EN
        check("op9_err", 32'(resp_err), 32'h1);
        check("op9_res", 32'(resp_result), 32'h0);
        check("op9_flg", 32'(resp_flags), 32'h0);
`else
        check("op9_err", 32'(resp_err), 32'h0);
`endif
        tick();
        req_op0   = 4'd1;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        #1;
        check("op1_rv", 32'(resp_valid), 32'h1);
        check("op1_err", 32'(resp_err), 32'h0);
        check("op1_res", 32'(resp_result), 32'h2);
        check("op1_flg", 32'(resp_flags), 32'h2);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
